reg_file_sb: RTL and testbench

Parametrised integer register file with a write enable, same-cycle write-to-read bypass and a per-register pending scoreboard. The decode stage marks a destination pending when it issues a long-latency op (mul/div, load, CSR). Writeback clears the pending bit. Hazard outputs stall decode until a source operand is available. x0 stays hardwired to zero.

---
 rtl/reg_file_sb.sv | 147 ++++++++++++++
 tb/tb_reg_file_sb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//   Integer register file with a per-register pending scoreboard.
//   - Two combinational read ports, optional same-cycle write-to-read bypass.
//   - One writeback port: writes data and clears the destination's pending bit.
//   - One issue port: marks a destination pending for a long-latency producer.
//   - x0 reads as zero, ignores writes and is never marked pending.
//   CNT_W must satisfy 2**CNT_W > 2**ADDR_W so the pending count cannot wrap.
//
// Ports
//   clk_in, reset_n_in            clock / asynchronous active-low reset
//   rs1_address_in, rs2_address_in read addresses
//   rs1_data_out, rs2_data_out    read data (combinational)
//   rs1_busy_out, rs2_busy_out    source operand still pending
//   issue_valid_in, issue_rd_in   mark destination pending
//   issue_waw_out                 destination already pending (advisory)
//   wr_en_in, wr_rd_in, wr_data_in writeback
//   pending_count_out             number of pending registers
//   all_idle_out                  nothing pending
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 6
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic [ADDR_W-1:0] rs1_address_in,
    input  logic [ADDR_W-1:0] rs2_address_in,
    output logic [XLEN-1:0]   rs1_data_out,
    output logic [XLEN-1:0]   rs2_data_out,
    output logic              rs1_busy_out,
    output logic              rs2_busy_out,
    input  logic              issue_valid_in,
    input  logic [ADDR_W-1:0] issue_rd_in,
    output logic              issue_waw_out,
    input  logic              wr_en_in,
    input  logic [ADDR_W-1:0] wr_rd_in,
    input  logic [XLEN-1:0]   wr_data_in,
    output logic [CNT_W-1:0]  pending_count_out,
    output logic              all_idle_out
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam bit BYP      = (BYPASS != 0);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [CNT_W-1:0]    pending_count;

    logic set_en;
    logic clr_en;
    logic set_same;
    logic cnt_inc;
    logic cnt_dec;

    // x0 never takes part in writes or the scoreboard.
    assign set_en   = issue_valid_in && (issue_rd_in != '0);
    assign clr_en   = wr_en_in && (wr_rd_in != '0);
    assign set_same = set_en && clr_en && (issue_rd_in == wr_rd_in);

    // Count tracks the popcount of pending: only real 0->1 / 1->0 transitions move it.
    assign cnt_inc = set_en && !pending[issue_rd_in];
    assign cnt_dec = clr_en && pending[wr_rd_in] && !set_same;

    // NOTE: the register array is reset because the architecture requires every
    // register to read zero after reset; that forces flops rather than a RAM macro.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_en) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            regs[wr_rd_in] <= wr_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            pending <= '0;
        end else begin
            if (clr_en) begin
                pending[wr_rd_in] <= 1'b0;
            end
            // Set is written last so it overrides a same-register clear: the
            // register stays pending for the newly issued producer.
            if (set_en) begin
                pending[issue_rd_in] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            pending_count <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   pending_count <= pending_count + CNT_W'(1);
                2'b01:   pending_count <= pending_count - CNT_W'(1);
                default: pending_count <= pending_count;
            endcase
        end
    end

    // Read ports share one description, indexed by port number.
    logic [ADDR_W-1:0] rs_addr [2];
    logic [XLEN-1:0]   rs_data [2];
    logic              rs_busy [2];

    assign rs_addr[0] = rs1_address_in;
    assign rs_addr[1] = rs2_address_in;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        for (int p = 0; p < 2; p++) begin
            rs_data[p] = '0;
            rs_busy[p] = 1'b0;
            // Outputs are forced quiet while reset is held, including the bypass path.
            if (reset_n_in && (rs_addr[p] != '0)) begin
                if (BYP && wr_en_in && (wr_rd_in == rs_addr[p])) begin
                    rs_data[p] = wr_data_in;
                    rs_busy[p] = 1'b0;
                end else begin
                    rs_data[p] = regs[rs_addr[p]];
                    rs_busy[p] = pending[rs_addr[p]];
                end
            end
        end
    end

    assign rs1_data_out = rs_data[0];
    assign rs2_data_out = rs_data[1];
    assign rs1_busy_out = rs_busy[0];
    assign rs2_busy_out = rs_busy[1];

    // A writeback to the same destination in this cycle resolves the hazard.
    assign issue_waw_out = reset_n_in && set_en && pending[issue_rd_in]
                           && !(wr_en_in && (wr_rd_in == issue_rd_in));

    assign pending_count_out = pending_count;
    assign all_idle_out      = (pending_count == '0);

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    logic        clk_in;
    logic        reset_n_in;
    logic [4:0]  rs1_address_in, rs2_address_in;
    logic        issue_valid_in;
    logic [4:0]  issue_rd_in;
    logic        wr_en_in;
    logic [4:0]  wr_rd_in;
    logic [31:0] wr_data_in;

    // BYPASS=1 instance
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy, waw, all_idle;
    logic [5:0]  pcount;

    // BYPASS=0 instance, same stimulus
    logic [31:0] nb_rs1_data, nb_rs2_data;
    logic        nb_rs1_busy, nb_rs2_busy, nb_waw, nb_all_idle;
    logic [5:0]  nb_pcount;

    reg_file_sb #(.XLEN(32), .ADDR_W(5), .BYPASS(1), .CNT_W(6)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .rs1_address_in(rs1_address_in), .rs2_address_in(rs2_address_in),
        .rs1_data_out(rs1_data), .rs2_data_out(rs2_data),
        .rs1_busy_out(rs1_busy), .rs2_busy_out(rs2_busy),
        .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in),
        .issue_waw_out(waw),
        .wr_en_in(wr_en_in), .wr_rd_in(wr_rd_in), .wr_data_in(wr_data_in),
        .pending_count_out(pcount), .all_idle_out(all_idle)
    );

    reg_file_sb #(.XLEN(32), .ADDR_W(5), .BYPASS(0), .CNT_W(6)) dut_nb (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .rs1_address_in(rs1_address_in), .rs2_address_in(rs2_address_in),
        .rs1_data_out(nb_rs1_data), .rs2_data_out(nb_rs2_data),
        .rs1_busy_out(nb_rs1_busy), .rs2_busy_out(nb_rs2_busy),
        .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in),
        .issue_waw_out(nb_waw),
        .wr_en_in(wr_en_in), .wr_rd_in(wr_rd_in), .wr_data_in(wr_data_in),
        .pending_count_out(nb_pcount), .all_idle_out(nb_all_idle)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_rd;
        logic [31:0] wr_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        iv;
        logic [4:0]  ird;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic        e_b1;
        logic        e_b2;
        logic        e_waw;
        logic [5:0]  e_cnt;
        logic [31:0] e_nb_rs2;
        logic        e_nb_b2;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(
        input logic we, input logic [4:0] wrd, input logic [31:0] wd,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic iv, input logic [4:0] ird,
        input logic [31:0] e1, input logic [31:0] e2,
        input logic b1, input logic b2, input logic ww, input logic [5:0] cnt,
        input logic [31:0] nb2, input logic nbb2);
        vec_t v;
        v.wr_en = we; v.wr_rd = wrd; v.wr_data = wd;
        v.rs1 = r1; v.rs2 = r2; v.iv = iv; v.ird = ird;
        v.e_rs1 = e1; v.e_rs2 = e2; v.e_b1 = b1; v.e_b2 = b2; v.e_waw = ww;
        v.e_cnt = cnt; v.e_nb_rs2 = nb2; v.e_nb_b2 = nbb2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a vector's inputs and queue its expected outputs.
    task automatic drive(input vec_t v);
        wr_en_in       = v.wr_en;
        wr_rd_in       = v.wr_rd;
        wr_data_in     = v.wr_data;
        rs1_address_in = v.rs1;
        rs2_address_in = v.rs2;
        issue_valid_in = v.iv;
        issue_rd_in    = v.ird;
        exp_q.push_back(v);
    endtask

    // Pop the oldest expectation and compare it against the DUT outputs.
    task automatic compare(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s.queue: got empty expected entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".rs1_data"}, rs1_data, e.e_rs1);
        check({tag, ".rs2_data"}, rs2_data, e.e_rs2);
        check({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(e.e_b1));
        check({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(e.e_b2));
        check({tag, ".waw"},      32'(waw), 32'(e.e_waw));
        check({tag, ".count"},    32'(pcount), 32'(e.e_cnt));
        check({tag, ".idle"},     32'(all_idle), 32'(e.e_cnt == 6'd0));
        check({tag, ".nb_rs2"},   nb_rs2_data, e.e_nb_rs2);
        check({tag, ".nb_busy2"}, 32'(nb_rs2_busy), 32'(e.e_nb_b2));
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk_in);
        drive(v);
        #2;
        compare(tag);
    endtask

    initial begin
        //        we wrd wdata         r1  r2  iv ird  e_rs1         e_rs2         b1 b2 waw cnt nb_rs2       nb_b2
        tbl.push_back(mk(0, 0, 32'h0,        5,  0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 1,  2, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        5,  0, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 0, 32'h1234,     0,  5, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0,  0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 7, 32'hA5A5A5A5, 5,  7, 0, 0, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        7,  3, 1, 3, 32'hA5A5A5A5, 32'h0,        0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        3,  7, 0, 0, 32'h0,        32'hA5A5A5A5, 1, 0, 0, 1, 32'hA5A5A5A5, 0));
        tbl.push_back(mk(1, 3, 32'h55,       3,  3, 0, 0, 32'h55,       32'h55,       0, 0, 0, 1, 32'h0,        1));
        tbl.push_back(mk(0, 0, 32'h0,        3,  3, 0, 0, 32'h55,       32'h55,       0, 0, 0, 0, 32'h55,       0));
        tbl.push_back(mk(0, 0, 32'h0,        9,  0, 1, 9, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        9,  9, 1, 9, 32'h0,        32'h0,        1, 1, 1, 1, 32'h0,        1));
        tbl.push_back(mk(1, 9, 32'h99,       9,  0, 1, 9, 32'h99,       32'h0,        0, 0, 0, 1, 32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        9,  9, 0, 0, 32'h99,       32'h99,       1, 1, 0, 1, 32'h99,       1));
        tbl.push_back(mk(1, 9, 32'h9A,       9,  4, 1, 0, 32'h9A,       32'h0,        0, 0, 0, 1, 32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        9,  0, 0, 0, 32'h9A,       32'h0,        0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 5, 32'h11,       5,  5, 0, 0, 32'h11,       32'h11,       0, 0, 0, 0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 0, 32'h0,        5,  0, 0, 0, 32'h11,       32'h0,        0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        10, 11, 1, 10, 32'h0,      32'h0,        0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 10, 32'h1,       10, 11, 1, 11, 32'h1,      32'h0,        0, 0, 0, 1, 32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        10, 11, 0, 0, 32'h1,       32'h0,        0, 1, 0, 1, 32'h0,        1));
        tbl.push_back(mk(1, 11, 32'h2,       0,  11, 0, 0, 32'h0,       32'h2,        0, 0, 0, 1, 32'h0,        1));
        tbl.push_back(mk(0, 0, 32'h0,        0,  11, 0, 0, 32'h0,       32'h2,        0, 0, 0, 0, 32'h2,        0));

        // Reset held: outputs quiet even with a bypassing write and an issue.
        reset_n_in = 1'b0;
        drive(mk(1, 5, 32'hFFFFFFFF, 5, 5, 1, 5, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0));
        repeat (2) @(posedge clk_in);
        #2;
        compare("rst_held");

        @(negedge clk_in);
        drive(mk(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0));
        exp_q.delete();
        reset_n_in = 1'b1;

        for (int i = 0; i < 32; i++) begin
            apply(mk(0, 0, 32'h0, 5'(i), 5'(31 - i), 0, 0,
                     32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0), $sformatf("rst_read%0d", i));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Build x4=0x77 with x4, x6, x8 pending, then reset between edges.
        apply(mk(1, 4, 32'h77, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  0), "mr0");
        apply(mk(0, 0, 32'h0,  4, 0, 1, 4, 32'h77, 32'h0,  0, 0, 0, 0, 32'h0,  0), "mr1");
        apply(mk(0, 0, 32'h0,  4, 0, 1, 6, 32'h77, 32'h0,  1, 0, 0, 1, 32'h0,  0), "mr2");
        apply(mk(0, 0, 32'h0,  4, 6, 1, 8, 32'h77, 32'h0,  1, 1, 0, 2, 32'h0,  1), "mr3");
        apply(mk(0, 0, 32'h0,  8, 4, 1, 8, 32'h0,  32'h77, 1, 1, 1, 3, 32'h77, 1), "mr4");

        @(negedge clk_in);
        drive(mk(1, 4, 32'h88, 4, 6, 1, 6, 32'h88, 32'h0, 0, 1, 1, 3, 32'h0, 1));
        #2;
        compare("mr_pre");
        #1;
        reset_n_in = 1'b0;
        #1;
        drive(mk(1, 4, 32'h88, 4, 6, 1, 6, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0));
        compare("mr_held");

        @(negedge clk_in);
        reset_n_in = 1'b1;
        drive(mk(0, 0, 32'h0, 4, 6, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0));
        #2;
        compare("mr_rel");
        apply(mk(0, 0, 32'h0, 8, 6, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0), "mr_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
